// File: rtl/arb4_rr_ctrl.sv
// Four-client round-robin arbiter. It drives a one-hot grant and limits how long one owner may hold it.
// Every grant is followed by at least one idle cycle before the next owner is chosen.
module arb4_rr_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HoldLimit = 8'(MAX_HOLD);

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [7:0] holdCnt_q;
    logic [3:0] gnt_q;
    logic [1:0] idx_q;
    logic       valid_q;
    logic       timeout_q;

    logic [1:0] pickIdx_d;
    logic [3:0] pickGnt_d;

    // Scanning the farthest offset first means the requester nearest the pointer is written last and wins.
    always_comb begin
        pickIdx_d = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr_q + 2'(i)]) begin
                pickIdx_d = ptr_q + 2'(i);
            end
        end
        pickGnt_d = 4'b0001 << pickIdx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'b00;
            holdCnt_q <= 8'd0;
            gnt_q     <= 4'b0000;
            idx_q     <= 2'b11;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (req != 4'b0000) begin
                        state_q   <= GRANT;
                        idx_q     <= pickIdx_d;
                        gnt_q     <= pickGnt_d;
                        valid_q   <= 1'b1;
                        holdCnt_q <= 8'd1;
                    end
                end
                GRANT: begin
                    // A release with the owner still requesting can only be the hold limit, so req[idx_q] is the timeout flag.
                    if (!req[idx_q] || holdCnt_q == HoldLimit) begin
                        state_q   <= IDLE;
                        gnt_q     <= 4'b0000;
                        valid_q   <= 1'b0;
                        ptr_q     <= idx_q + 2'd1;
                        timeout_q <= req[idx_q];
                    end else begin
                        holdCnt_q <= holdCnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Scoreboard bench for arb4_rr_ctrl: four instances with different hold limits share the stimulus.
// Each step queues the expected output of the selected instance, and a monitor compares it at the following falling edge.
module tb_arb4_rr_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;

    logic [3:0] gnt8, gnt2, gnt4, gnt1;
    logic [1:0] idx8, idx2, idx4, idx1;
    logic       vld8, vld2, vld4, vld1;
    logic       tmo8, tmo2, tmo4, tmo1;

    typedef struct {
        int         sel;
        int         tag;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       tmo;
    } expT;

    expT expQ[$];
    int  checkCount = 0;
    int  passCount  = 0;
    int  stepTag    = 0;

    always #5 clk = ~clk;

    arb4_rr_ctrl #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(vld8), .timeout(tmo8)
    );
    arb4_rr_ctrl #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(vld2), .timeout(tmo2)
    );
    arb4_rr_ctrl #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4), .timeout(tmo4)
    );
    arb4_rr_ctrl #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1), .timeout(tmo1)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
        checkCount++;
        if (actual === required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got {gnt,idx,vld,tmo}=%b_%b_%b_%b expected %b_%b_%b_%b", name,
                     actual[7:4], actual[3:2], actual[1], actual[0],
                     required[7:4], required[3:2], required[1], required[0]);
        end
    endtask

    task automatic pushExp(input int sel, input logic [3:0] eg, input logic [1:0] ei,
                           input logic ev, input logic et);
        expT e;
        e.sel   = sel;
        e.tag   = stepTag;
        e.gnt   = eg;
        e.idx   = ei;
        e.valid = ev;
        e.tmo   = et;
        expQ.push_back(e);
        stepTag++;
    endtask

    // Drive req for one clock; the expectation describes the outputs just after that edge.
    task automatic applyStimulus(input int sel, input logic [3:0] r, input logic [3:0] eg,
                                 input logic [1:0] ei, input logic ev, input logic et);
        req = r;
        @(posedge clk);
        pushExp(sel, eg, ei, ev, et);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        req   = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reset lands between edges while a grant is active; the outputs must clear before the next edge.
    task automatic resetMidGrant(input int sel, input logic [3:0] r);
        req = r;
        @(posedge clk);
        pushExp(sel, 4'b0000, 2'b11, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        expT        e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                case (e.sel)
                    0:       act = {gnt8, idx8, vld8, tmo8};
                    1:       act = {gnt2, idx2, vld2, tmo2};
                    2:       act = {gnt4, idx4, vld4, tmo4};
                    default: act = {gnt1, idx1, vld1, tmo1};
                endcase
                checkOutput($sformatf("step%0d", e.tag), act, {e.gnt, e.idx, e.valid, e.tmo});
            end
        end
    end

    initial begin
        doReset();

        // Idle after reset (hold 8)
        for (int i = 0; i < 10; i++) applyStimulus(0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Single requester, voluntary release, then pointer starts at 3
        applyStimulus(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
        applyStimulus(0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
        applyStimulus(0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Pointer wrap and skip of idle clients
        applyStimulus(0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        applyStimulus(0, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Round-robin under saturation (hold 2)
        doReset();
        applyStimulus(1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b1);
        applyStimulus(1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b1);
        applyStimulus(1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b1);
        applyStimulus(1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Starvation guard, then a lone forced owner winning again (hold 4)
        doReset();
        applyStimulus(2, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(2, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(2, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(2, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(2, 4'b0101, 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(2, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(2, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(2, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(2, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(2, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(2, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Hold limit of one gives grant, gap, grant, gap
        doReset();
        applyStimulus(3, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(3, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(3, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(3, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b1);
        applyStimulus(3, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(3, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b1);
        applyStimulus(3, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // Reset in the middle of a grant while the pointer sits at 1
        doReset();
        applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        resetMidGrant(0, 4'b0010);
        applyStimulus(0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checkCount++;
        if (expQ.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/arb4_rr_ctrl.md
# arb4_rr_ctrl

Four-requester round-robin arbiter that shares one resource among four clients and drives a one-hot grant bus. Internally the 2-bit owner index is decoded to the 4-bit one-hot grant. A hold counter bounds tenure so no requester can starve the others. The block sits between the request lines of four client blocks and the enable/select inputs of the shared resource.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[k] high means client k wants or is using the resource.
- gnt  output  4  one-hot grant; all-zero when idle; gnt[k] = (gnt_valid && gnt_idx==k).
- gnt_idx  output  2  index of the current owner; holds the last owner while idle.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse in the cycle after a grant is forcibly ended by MAX_HOLD.

## Operation
- Single clock and asynchronous active-low reset, as already decided.
- All outputs are registered.
- Reset values:
  - gnt=4'b0000, gnt_idx=2'b11, gnt_valid=0, timeout=0.
  - Priority pointer ptr=2'b00, hold_cnt=0, state=IDLE.
- Two states:
  - IDLE:
    - gnt=0.
    - If req!=0, select the first k with req[k]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    - Next state GRANT, gnt_idx=k, hold_cnt=1.
    - If req==0, stay in IDLE.
  - GRANT (owner o=gnt_idx):
    - Voluntary release: req[o]=0 sampled. Next state IDLE, gnt_valid=0, ptr=o+1 mod 4, timeout stays 0.
    - Forced release: req[o]=1 and hold_cnt==MAX_HOLD. Next state IDLE, gnt_valid=0, ptr=o+1 mod 4, timeout=1 for exactly one cycle.
    - Otherwise stay in GRANT and increment hold_cnt.
- IDLE always lasts at least one cycle between grants (a bus-turnaround gap). Grant-to-grant hand-off is never zero-cycle.
- ptr wraps 3→0. With all four requesting continuously, the grant order is 0,1,2,3,0,...
- Requests from non-owners during GRANT are ignored until the next IDLE cycle. No preemption except by MAX_HOLD.
- A forcibly released owner that keeps req high is re-arbitrated like any other requester. It wins again only if no other request exists.
- Asserting rst_n low at any time, including mid-grant, immediately returns every output and register to its reset value. No grant survives reset.
- gnt is always one-hot or zero; never more than one bit set.

## Timing
- Arbitration latency: req sampled at edge N in IDLE → gnt valid after edge N (1 cycle).
- Release latency: req[o] dropped before edge N → gnt deasserted after edge N. Next grant is possible after edge N+1.
- With MAX_HOLD=M and req held, gnt is high for exactly M cycles, then 1 IDLE cycle. timeout is high during that IDLE cycle.
- MAX_HOLD=1: every grant lasts one cycle. Under saturation the pattern is grant, gap, grant, gap.
- Reset deassertion is synchronous to clk for the counters. The first arbitration occurs at the first rising edge with rst_n high.

## Test plan
- Reset/idle: rst_n=0 then release with req=0 → gnt=0000, gnt_valid=0, gnt_idx=11, timeout=0 for 10 cycles.
- Single requester: req=0100 for 3 cycles then 0000, MAX_HOLD=8 → gnt=0100 for 3 cycles starting 1 cycle after req, then 0000; timeout never set; next arbitration starts from ptr=3.
- Round-robin fairness: req=1111 held, MAX_HOLD=2 → gnt sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001,...; timeout pulses in each 0000 cycle.
- Pointer wrap/skip: after client 3 releases voluntarily (ptr=0), apply req=1010 → gnt=0010; after release, req=1010 → gnt=1000.
- Starvation guard: req=0001 held, req[2] raised at cycle 2, MAX_HOLD=4 → gnt=0001 for 4 cycles, timeout pulse, then gnt=0100.
- Reset mid-grant: during gnt=0010 assert rst_n=0 asynchronously between edges → gnt=0000, gnt_valid=0 immediately; after release with req=0011 → gnt=0001 (ptr back to 0).
